nway_issue_hazard_unit: RTL and testbench

- Parametrised N-wide successor to the dual-issue hazard logic in the 5-stage superscalar RISC-V pipeline.
- Receives the decoded D-stage bundle and issues slots in order, which allows partial issue. It remembers already-issued slots in a done mask, so a bundle replays without re-issuing them.
- Tracks E/M/W producers per slot internally and generates per-slot forwarding selects, F/D stalls and flushes.
- Sits between the decode registers and the E-stage pipeline registers of the datapath.

---
 rtl/nway_issue_hazard_unit_pkg.sv | 13 +
 rtl/nway_issue_hazard_unit_if.sv | 27 ++
 rtl/nway_issue_hazard_unit_fwd_select.sv | 37 +++
 rtl/nway_issue_hazard_unit.sv | 162 ++++++++++++++++
 tb/tb_nway_issue_hazard_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/nway_issue_hazard_unit_pkg.sv
// Shared constants for the N-wide issue hazard unit.
// Forward-select stage codes and slot-index width helper.
package nway_issue_hazard_unit_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  function automatic int sw_of(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/nway_issue_hazard_unit_if.sv
// Decoded D-stage bundle handed from decode to the hazard unit.
// Decode drives it as master; the hazard unit reads it as slave.
interface nway_issue_hazard_unit_if #(
  parameter int ISSUE_W = 2,
  parameter int REG_AW  = 5
);

  logic [ISSUE_W-1:0]        dec_valid_i;
  logic [ISSUE_W*REG_AW-1:0] dec_rs1_i;
  logic [ISSUE_W*REG_AW-1:0] dec_rs2_i;
  logic [ISSUE_W-1:0]        dec_rs2_used_i;
  logic [ISSUE_W*REG_AW-1:0] dec_rd_i;
  logic [ISSUE_W-1:0]        dec_regwrite_i;
  logic [ISSUE_W-1:0]        dec_isload_i;
  logic [ISSUE_W-1:0]        dec_ctrl_i;

  modport master (
    output dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs2_used_i,
    output dec_rd_i, dec_regwrite_i, dec_isload_i, dec_ctrl_i
  );

  modport slave (
    input dec_valid_i, dec_rs1_i, dec_rs2_i, dec_rs2_used_i,
    input dec_rd_i, dec_regwrite_i, dec_isload_i, dec_ctrl_i
  );

endinterface

// File: rtl/nway_issue_hazard_unit_fwd_select.sv
// Priority forward search for one E-stage source register.
// M beats W; within a stage the highest (youngest) slot wins.
module nway_fwd_select
  import nway_issue_hazard_unit_pkg::*;
#(
  parameter int ISSUE_W = 2,
  parameter int REG_AW  = 5,
  parameter int SW      = 1
) (
  input  logic [REG_AW-1:0]         src_i,
  input  logic [ISSUE_W-1:0]        m_v_i,
  input  logic [ISSUE_W-1:0]        m_rw_i,
  input  logic [ISSUE_W*REG_AW-1:0] m_rd_i,
  input  logic [ISSUE_W-1:0]        w_v_i,
  input  logic [ISSUE_W-1:0]        w_rw_i,
  input  logic [ISSUE_W*REG_AW-1:0] w_rd_i,
  output logic [SW+1:0]             sel_o
);

  // Later assignments override earlier ones, giving the priority order.
  always_comb begin
    sel_o = {{SW{1'b0}}, FWD_RF};
    if (src_i != '0) begin
      for (int k = 0; k < ISSUE_W; k++) begin
        if (w_v_i[k] && w_rw_i[k] &&
            w_rd_i[k*REG_AW +: REG_AW] == src_i)
          sel_o = {SW'(k), FWD_WB};
      end
      for (int k = 0; k < ISSUE_W; k++) begin
        if (m_v_i[k] && m_rw_i[k] &&
            m_rd_i[k*REG_AW +: REG_AW] == src_i)
          sel_o = {SW'(k), FWD_MEM};
      end
    end
  end

endmodule

// File: rtl/nway_issue_hazard_unit.sv
// N-wide in-order issue, hazard detection and forwarding control.
// Partial issue is remembered in done_q so a replay skips issued slots.
module nway_issue_hazard_unit
  import nway_issue_hazard_unit_pkg::*;
#(
  parameter  int ISSUE_W = 2,
  parameter  int REG_AW  = 5,
  localparam int SW      = sw_of(ISSUE_W)
) (
  input  logic                      clk,
  input  logic                      reset,
  nway_issue_hazard_unit_if.slave   dec,
  input  logic                      mispredict_i,
  output logic [ISSUE_W-1:0]        issue_o,
  output logic                      stall_f_o,
  output logic                      stall_d_o,
  output logic                      flush_d_o,
  output logic [ISSUE_W-1:0]        flush_e_o,
  output logic [ISSUE_W*(SW+2)-1:0] fwd_a_o,
  output logic [ISSUE_W*(SW+2)-1:0] fwd_b_o
);

  localparam int RW = ISSUE_W * REG_AW;

  logic [ISSUE_W-1:0] done_q, done_d;
  logic [ISSUE_W-1:0] e_v_q, e_v_d, e_rw_q, e_rw_d;
  logic [ISSUE_W-1:0] e_ld_q, e_ld_d;
  logic [RW-1:0]      e_rd_q, e_rd_d;
  logic [RW-1:0]      e_rs1_q, e_rs1_d, e_rs2_q, e_rs2_d;
  logic [ISSUE_W-1:0] m_v_q, m_v_d, m_rw_q, m_rw_d;
  logic [RW-1:0]      m_rd_q, m_rd_d;
  logic [ISSUE_W-1:0] w_v_q, w_v_d, w_rw_q, w_rw_d;
  logic [RW-1:0]      w_rd_q, w_rd_d;

  logic [ISSUE_W-1:0] pend, haz, issue;
  logic               all_done;
  logic [REG_AW-1:0]  rs1_w [ISSUE_W];
  logic [REG_AW-1:0]  rs2_w [ISSUE_W];
  logic [REG_AW-1:0]  rd_w  [ISSUE_W];

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_unpack
    assign rs1_w[i] = dec.dec_rs1_i[i*REG_AW +: REG_AW];
    assign rs2_w[i] = dec.dec_rs2_i[i*REG_AW +: REG_AW];
    assign rd_w[i]  = dec.dec_rd_i[i*REG_AW +: REG_AW];
  end

  always_comb begin
    pend = dec.dec_valid_i & ~done_q;
    haz  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      for (int j = 0; j < i; j++) begin
        if (pend[j] && dec.dec_ctrl_i[j])
          haz[i] = 1'b1;
        if (pend[j] && dec.dec_regwrite_i[j] && rd_w[j] != '0 &&
            (rd_w[j] == rs1_w[i] || rd_w[j] == rd_w[i] ||
             (dec.dec_rs2_used_i[i] && rd_w[j] == rs2_w[i])))
          haz[i] = 1'b1;
      end
      // Load-use: the loaded value is not ready until after M.
      for (int k = 0; k < ISSUE_W; k++) begin
        if (e_v_q[k] && e_ld_q[k] &&
            e_rd_q[k*REG_AW +: REG_AW] != '0 &&
            (e_rd_q[k*REG_AW +: REG_AW] == rs1_w[i] ||
             (dec.dec_rs2_used_i[i] &&
              e_rd_q[k*REG_AW +: REG_AW] == rs2_w[i])))
          haz[i] = 1'b1;
      end
    end
  end

  always_comb begin
    logic ok;
    ok    = 1'b1;
    issue = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      issue[i] = pend[i] & ~haz[i] & ~mispredict_i & ok;
      ok = ok & ~(pend[i] & ~issue[i]);
    end
  end

  assign all_done  = &(~dec.dec_valid_i | done_q | issue);
  assign issue_o   = issue;
  assign stall_f_o = ~all_done & ~mispredict_i;
  assign stall_d_o = ~all_done & ~mispredict_i;
  assign flush_d_o = mispredict_i;
  assign flush_e_o = {ISSUE_W{mispredict_i}} | ~issue;

  always_comb begin
    done_d  = (mispredict_i || all_done) ? '0 : (done_q | issue);
    e_v_d   = issue & ~{ISSUE_W{mispredict_i}};
    e_rw_d  = issue & dec.dec_regwrite_i;
    e_ld_d  = issue & dec.dec_isload_i;
    e_rd_d  = '0;
    e_rs1_d = '0;
    e_rs2_d = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (issue[i]) begin
        e_rd_d[i*REG_AW +: REG_AW]  = rd_w[i];
        e_rs1_d[i*REG_AW +: REG_AW] = rs1_w[i];
        e_rs2_d[i*REG_AW +: REG_AW] = rs2_w[i];
      end
    end
    m_v_d  = e_v_q;
    m_rw_d = e_rw_q;
    m_rd_d = e_rd_q;
    w_v_d  = m_v_q;
    w_rw_d = m_rw_q;
    w_rd_d = m_rd_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_q  <= '0;
      e_v_q   <= '0;
      e_rw_q  <= '0;
      e_ld_q  <= '0;
      e_rd_q  <= '0;
      e_rs1_q <= '0;
      e_rs2_q <= '0;
      m_v_q   <= '0;
      m_rw_q  <= '0;
      m_rd_q  <= '0;
      w_v_q   <= '0;
      w_rw_q  <= '0;
      w_rd_q  <= '0;
    end else begin
      done_q  <= done_d;
      e_v_q   <= e_v_d;
      e_rw_q  <= e_rw_d;
      e_ld_q  <= e_ld_d;
      e_rd_q  <= e_rd_d;
      e_rs1_q <= e_rs1_d;
      e_rs2_q <= e_rs2_d;
      m_v_q   <= m_v_d;
      m_rw_q  <= m_rw_d;
      m_rd_q  <= m_rd_d;
      w_v_q   <= w_v_d;
      w_rw_q  <= w_rw_d;
      w_rd_q  <= w_rd_d;
    end
  end

  for (genvar i = 0; i < ISSUE_W; i++) begin : g_fwd
    nway_fwd_select #(
      .ISSUE_W(ISSUE_W), .REG_AW(REG_AW), .SW(SW)
    ) u_fwd_a (
      .src_i (e_rs1_q[i*REG_AW +: REG_AW]),
      .m_v_i (m_v_q), .m_rw_i(m_rw_q), .m_rd_i(m_rd_q),
      .w_v_i (w_v_q), .w_rw_i(w_rw_q), .w_rd_i(w_rd_q),
      .sel_o (fwd_a_o[i*(SW+2) +: SW+2])
    );
    nway_fwd_select #(
      .ISSUE_W(ISSUE_W), .REG_AW(REG_AW), .SW(SW)
    ) u_fwd_b (
      .src_i (e_rs2_q[i*REG_AW +: REG_AW]),
      .m_v_i (m_v_q), .m_rw_i(m_rw_q), .m_rd_i(m_rd_q),
      .w_v_i (w_v_q), .w_rw_i(w_rw_q), .w_rd_i(w_rd_q),
      .sel_o (fwd_b_o[i*(SW+2) +: SW+2])
    );
  end

endmodule

// File: tb/tb_nway_issue_hazard_unit.sv
// Self-checking bench: directed scenarios, then random bundles
// compared each cycle against an instruction-level pipeline model.
module tb_nway_issue_hazard_unit;

  localparam int W  = 2;
  localparam int AW = 5;
  localparam int SW = 1;
  localparam int FW = SW + 2;

  typedef struct {
    bit v; int rs1; int rs2; bit u;
    int rd; bit rw; bit ld; bit ctrl;
  } ins_t;

  typedef struct {
    bit v; int rd; bit rw; bit ld; int rs1; int rs2;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mispredict_i = 1'b0;
  logic [W-1:0]  issue_o;
  logic          stall_f_o, stall_d_o, flush_d_o;
  logic [W-1:0]  flush_e_o;
  logic [W*FW-1:0] fwd_a_o, fwd_b_o;

  nway_issue_hazard_unit_if #(.ISSUE_W(W), .REG_AW(AW)) dif ();

  nway_issue_hazard_unit #(.ISSUE_W(W), .REG_AW(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .dec          (dif.slave),
    .mispredict_i (mispredict_i),
    .issue_o      (issue_o),
    .stall_f_o    (stall_f_o),
    .stall_d_o    (stall_d_o),
    .flush_d_o    (flush_d_o),
    .flush_e_o    (flush_e_o),
    .fwd_a_o      (fwd_a_o),
    .fwd_b_o      (fwd_b_o)
  );

  always #5 clk = ~clk;

  ins_t bun [W];
  ent_t pe [W], pm [W], pw [W];
  bit   done [W];
  bit   mis, rst, x_stall;
  logic [W-1:0]    got_issue, got_fe;
  logic            got_stall;
  logic [W*FW-1:0] got_fa, got_fb;
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit reads(input ins_t s, input int r);
    return r != 0 && (s.rs1 == r || (s.u && s.rs2 == r));
  endfunction

  // Youngest producer in the nearest stage supplies the operand.
  function automatic logic [FW-1:0] fwd_exp(input int r);
    if (r == 0) return '0;
    for (int k = W - 1; k >= 0; k--)
      if (pm[k].v && pm[k].rw && pm[k].rd == r) return FW'(k * 4 + 2);
    for (int k = W - 1; k >= 0; k--)
      if (pw[k].v && pw[k].rw && pw[k].rd == r) return FW'(k * 4 + 1);
    return '0;
  endfunction

  task automatic drive();
    for (int i = 0; i < W; i++) begin
      dif.dec_valid_i[i]          = bun[i].v;
      dif.dec_rs1_i[i*AW +: AW]   = AW'(bun[i].rs1);
      dif.dec_rs2_i[i*AW +: AW]   = AW'(bun[i].rs2);
      dif.dec_rs2_used_i[i]       = bun[i].u;
      dif.dec_rd_i[i*AW +: AW]    = AW'(bun[i].rd);
      dif.dec_regwrite_i[i]       = bun[i].rw;
      dif.dec_isload_i[i]         = bun[i].ld;
      dif.dec_ctrl_i[i]           = bun[i].ctrl;
    end
    mispredict_i = mis;
    reset        = rst;
  endtask

  task automatic clear_bundle();
    for (int i = 0; i < W; i++) bun[i] = '{default: 0};
  endtask

  task automatic rand_bundle();
    for (int i = 0; i < W; i++) begin
      bun[i].v    = ($urandom % 4) != 0;
      bun[i].rs1  = $urandom % 4;
      bun[i].rs2  = $urandom % 4;
      bun[i].u    = $urandom % 2;
      bun[i].rd   = $urandom % 4;
      bun[i].rw   = $urandom % 4 != 0;
      bun[i].ld   = bun[i].rw && ($urandom % 3 == 0);
      bun[i].ctrl = ($urandom % 6) == 0;
    end
  endtask

  task automatic step();
    bit xi [W];
    bit blocked, all_ok, pend, haz;
    logic [W-1:0] xv, xfe;
    drive();
    #1;
    blocked = 0;
    all_ok  = 1;
    for (int i = 0; i < W; i++) begin
      pend = bun[i].v && !done[i];
      haz  = 0;
      for (int j = 0; j < i; j++) begin
        if (bun[j].v && !done[j]) begin
          if (bun[j].ctrl) haz = 1;
          if (bun[j].rw && bun[j].rd != 0 &&
              (reads(bun[i], bun[j].rd) || bun[i].rd == bun[j].rd))
            haz = 1;
        end
      end
      for (int k = 0; k < W; k++)
        if (pe[k].v && pe[k].ld && reads(bun[i], pe[k].rd)) haz = 1;
      xi[i] = pend && !haz && !mis && !blocked;
      if (pend && !xi[i]) blocked = 1;
      if (bun[i].v && !done[i] && !xi[i]) all_ok = 0;
    end
    x_stall = !all_ok && !mis;
    for (int i = 0; i < W; i++) begin
      xv[i]  = xi[i];
      xfe[i] = mis || !xi[i];
    end
    got_issue = issue_o;
    got_stall = stall_d_o;
    got_fe    = flush_e_o;
    got_fa    = fwd_a_o;
    got_fb    = fwd_b_o;
    check("issue", issue_o, xv);
    check("stall_f", stall_f_o, x_stall);
    check("stall_d", stall_d_o, x_stall);
    check("flush_d", flush_d_o, mis);
    check("flush_e", flush_e_o, xfe);
    for (int i = 0; i < W; i++) begin
      check("fwd_a", fwd_a_o[i*FW +: FW], fwd_exp(pe[i].rs1));
      check("fwd_b", fwd_b_o[i*FW +: FW], fwd_exp(pe[i].rs2));
    end
    if (rst) begin
      for (int i = 0; i < W; i++) begin
        pe[i] = '{default: 0};
        pm[i] = '{default: 0};
        pw[i] = '{default: 0};
        done[i] = 0;
      end
    end else begin
      for (int i = 0; i < W; i++) begin
        pw[i] = pm[i];
        pm[i] = pe[i];
        if (xi[i])
          pe[i] = '{1, bun[i].rd, bun[i].rw, bun[i].ld,
                    bun[i].rs1, bun[i].rs2};
        else
          pe[i] = '{default: 0};
        done[i] = (mis || all_ok) ? 0 : (done[i] || xi[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_bundle();
    mis = 0;
    rst = 1;
    drive();
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < W; i++) begin
      pe[i] = '{default: 0};
      pm[i] = '{default: 0};
      pw[i] = '{default: 0};
      done[i] = 0;
    end
    rst = 0;
    step();
    check("rst_issue", got_issue, 2'b00);
    check("rst_stall", got_stall, 1'b0);
    check("rst_fwd", got_fa, '0);

    bun[0] = '{1, 0, 0, 1, 1, 1, 0, 0};
    bun[1] = '{1, 0, 0, 1, 2, 1, 0, 0};
    step();
    check("indep_issue", got_issue, 2'b11);
    check("indep_stall", got_stall, 1'b0);

    bun[0] = '{1, 0, 0, 0, 5, 1, 0, 0};
    bun[1] = '{1, 5, 5, 1, 6, 1, 0, 0};
    step();
    check("raw_c0_issue", got_issue, 2'b01);
    check("raw_c0_stall", got_stall, 1'b1);
    step();
    check("raw_c1_issue", got_issue, 2'b10);
    check("raw_c1_stall", got_stall, 1'b0);
    clear_bundle();
    step();
    check("raw_c2_fwd_a", got_fa[FW +: FW], 3'b010);
    check("raw_c2_fwd_b", got_fb[FW +: FW], 3'b010);

    bun[1] = '{1, 0, 0, 0, 3, 1, 1, 0};
    step();
    check("lw_issue", got_issue, 2'b10);
    clear_bundle();
    bun[0] = '{1, 3, 0, 0, 8, 1, 0, 0};
    step();
    check("lu_issue", got_issue, 2'b00);
    check("lu_stall", got_stall, 1'b1);
    step();
    check("lu_next_issue", got_issue, 2'b01);
    clear_bundle();
    step();
    check("lu_fwd_a", got_fa[0 +: FW], 3'b101);

    bun[0] = '{1, 1, 2, 1, 0, 0, 0, 1};
    bun[1] = '{1, 0, 0, 0, 4, 1, 0, 0};
    step();
    check("br_issue", got_issue, 2'b01);
    mis = 1;
    step();
    check("mp_issue", got_issue, 2'b00);
    check("mp_flush_e", got_fe, 2'b11);
    check("mp_stall", got_stall, 1'b0);
    mis = 0;

    bun[0] = '{1, 0, 0, 0, 7, 1, 0, 0};
    bun[1] = '{1, 0, 0, 0, 7, 1, 0, 0};
    step();
    check("waw_c0", got_issue, 2'b01);
    step();
    check("waw_c1", got_issue, 2'b10);
    clear_bundle();
    bun[0] = '{1, 7, 0, 0, 9, 1, 0, 0};
    step();
    step();
    check("waw_fwd", got_fa[0 +: FW], 3'b110);

    for (int n = 0; n < 3000; n++) begin
      mis = ($urandom % 10) == 0;
      rst = ($urandom % 50) == 0;
      if (!x_stall || mis || rst) rand_bundle();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
